// File: rtl/off_chip_pkg.sv
// Shared definitions for the off-chip link blocks.
//   - ser_state_e : serializer FSM state encoding (3 bits)
//   - FRAME_BITS  : bits per frame for the default 16-bit word (start + data + parity + stop)
//   - *_LVL       : serial line levels for start, stop and idle
package off_chip_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAME_BITS = DATA_W_DEF + 3;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } ser_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and word; ignored when full unless a pop happens on the same edge
//   pop             read request; ignored when empty
//   rdata           word at the head of the FIFO (valid while !empty)
//   full, empty     registered occupancy flags
//   count           registered occupancy, 0..2**FIFO_AW
module sync_fifo #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               pop,
  output logic [DATA_W-1:0]  rdata,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [FIFO_AW:0]   count_next_s;
  logic               full_r;
  logic               empty_r;
  logic               do_pop_s;
  logic               do_push_s;

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign do_pop_s  = pop & ~empty_r;
  assign do_push_s = push & (~full_r | do_pop_s);

  // Next occupancy; push+pop together leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + (FIFO_AW + 1)'(1);
      2'b01:   count_next_s = count_r - (FIFO_AW + 1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; no reset needed, contents are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers (wrap modulo depth by width), occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_C);
      empty_r <= (count_next_s == '0);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/lfsr_word_serializer.sv
// Buffers words from the LFSR pattern generator and sends each as a serial frame:
// start(0), DATA_W data bits MSB-first, even parity, stop(1); CLK_DIV clocks per bit.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_cmd       1-cycle write strobe qualifying datain
//   datain       word to send
//   clr_stats    synchronous clear of overflow and words_sent
//   ser_out      serial line, idle high (registered)
//   ser_frame    high for every cycle of a frame (registered)
//   fifo_full    FIFO holds 2**FIFO_AW words
//   fifo_empty   FIFO holds no words
//   overflow     sticky: a word was dropped
//   words_sent   completed frames, wraps modulo 2^16
module lfsr_word_serializer
  import off_chip_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 3,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_cmd,
  input  logic [DATA_W-1:0]  datain,
  input  logic               clr_stats,
  output logic               ser_out,
  output logic               ser_frame,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic               overflow,
  output logic [15:0]        words_sent
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  // Even parity bit: makes the count of 1s over word+parity even.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    even_parity = ^word;
  endfunction

  ser_state_e         state_r;
  logic [7:0]         div_r;
  logic [BIT_W-1:0]   bit_r;
  logic [DATA_W-1:0]  shift_r;
  logic               parity_r;
  logic               ser_out_r;
  logic               ser_frame_r;
  logic               overflow_r;
  logic [15:0]        words_sent_r;

  logic [DATA_W-1:0]  fifo_rdata_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [FIFO_AW:0]   fifo_count_s;
  logic               has_word_s;
  logic               div_last_s;
  logic               pop_s;
  logic               drop_s;
  logic               frame_end_s;

  assign has_word_s  = (fifo_count_s != '0);
  assign div_last_s  = (div_r == DIV_LAST);
  assign frame_end_s = (state_r == ST_STOP) & div_last_s;
  // Words leave the FIFO only when a frame starts: from IDLE, or straight out of STOP.
  assign pop_s       = has_word_s & ((state_r == ST_IDLE) | frame_end_s);
  assign drop_s      = wr_cmd & fifo_full_s & ~pop_s;

  sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_cmd),
    .wdata (datain),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Frame FSM: line level and frame flag are registered together with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      div_r       <= 8'd0;
      bit_r       <= '0;
      shift_r     <= '0;
      parity_r    <= 1'b0;
      ser_out_r   <= IDLE_LVL;
      ser_frame_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          div_r <= 8'd0;
          bit_r <= '0;
          if (pop_s) begin
            state_r     <= ST_START;
            shift_r     <= fifo_rdata_s;
            parity_r    <= even_parity(fifo_rdata_s);
            ser_out_r   <= START_LVL;
            ser_frame_r <= 1'b1;
          end else begin
            ser_out_r   <= IDLE_LVL;
            ser_frame_r <= 1'b0;
          end
        end
        ST_START: begin
          if (div_last_s) begin
            state_r   <= ST_DATA;
            div_r     <= 8'd0;
            bit_r     <= '0;
            ser_out_r <= shift_r[DATA_W-1];
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        ST_DATA: begin
          if (div_last_s) begin
            div_r <= 8'd0;
            if (bit_r == BIT_LAST) begin
              state_r   <= ST_PARITY;
              ser_out_r <= parity_r;
            end else begin
              // The next line value is the bit that becomes MSB after this shift.
              bit_r     <= bit_r + BIT_W'(1);
              shift_r   <= {shift_r[DATA_W-2:0], 1'b0};
              ser_out_r <= shift_r[DATA_W-2];
            end
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        ST_PARITY: begin
          if (div_last_s) begin
            state_r   <= ST_STOP;
            div_r     <= 8'd0;
            ser_out_r <= STOP_LVL;
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        ST_STOP: begin
          if (div_last_s) begin
            div_r <= 8'd0;
            bit_r <= '0;
            if (pop_s) begin
              // Back-to-back frame: no idle cycle between stop and the next start.
              state_r     <= ST_START;
              shift_r     <= fifo_rdata_s;
              parity_r    <= even_parity(fifo_rdata_s);
              ser_out_r   <= START_LVL;
              ser_frame_r <= 1'b1;
            end else begin
              state_r     <= ST_IDLE;
              ser_out_r   <= IDLE_LVL;
              ser_frame_r <= 1'b0;
            end
          end else begin
            div_r <= div_r + 8'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          div_r       <= 8'd0;
          bit_r       <= '0;
          ser_out_r   <= IDLE_LVL;
          ser_frame_r <= 1'b0;
        end
      endcase
    end
  end

  // Statistics: a same-edge drop or frame end takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r   <= 1'b0;
      words_sent_r <= 16'd0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_stats) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (frame_end_s) begin
        words_sent_r <= clr_stats ? 16'd1 : (words_sent_r + 16'd1);
      end else if (clr_stats) begin
        words_sent_r <= 16'd0;
      end else begin
        words_sent_r <= words_sent_r;
      end
    end
  end

  assign ser_out    = ser_out_r;
  assign ser_frame  = ser_frame_r;
  assign fifo_full  = fifo_full_s;
  assign fifo_empty = fifo_empty_s;
  assign overflow   = overflow_r;
  assign words_sent = words_sent_r;

endmodule
